// File: rtl/iob_timed_device.sv
// PDP-6 I/O-bus slave: data buffer, CONO/CONI status, busy timer and PI request.
// Optional overrun flag (status bit 30) enabled by IOB_TIMED_DEVICE_OVERRUN_EN.
module iob_timed_device #(
    parameter logic [6:0] DEVICE_CODE = 7'o070,
    parameter int         XFER_CYCLES = 16,
    parameter int         CNT_W       = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        iob_poweron,
    input  logic        iob_reset,
    input  logic        datao_clear,
    input  logic        datao_set,
    input  logic        cono_clear,
    input  logic        cono_set,
    input  logic        iob_fm_datai,
    input  logic        iob_fm_status,
    input  logic [3:9]  ios,
    input  logic [0:35] iob_write,
    output logic [1:7]  pi_req,
    output logic [0:35] iob_read
);

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(XFER_CYCLES);

    logic             sel;
    logic             rst;
    logic             datai_act;
    logic             datai_prev;
    logic             datai_edge;
    logic [0:35]      db, db_n;
    logic [2:0]       pia, pia_n;
    logic             busy, busy_n;
    logic             done, done_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             req_active;
    logic [1:7]       pi_n;
    logic [0:35]      status;

    assign sel        = (ios == DEVICE_CODE);
    assign rst        = !reset || !iob_poweron || iob_reset;
    assign datai_act  = iob_fm_datai && sel;
    assign datai_edge = datai_act && !datai_prev;

`ifdef IOB_TIMED_DEVICE_OVERRUN_EN
    logic ovr, ovr_n;

    always_comb begin
        ovr_n = ovr;
        if (sel && cono_clear)
            ovr_n = 1'b0;
        else if (sel && datao_set && busy)
            ovr_n = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            ovr <= 1'b0;
        else
            ovr <= ovr_n;
    end

    assign req_active = done || ovr;
`else
    assign req_active = done;
`endif

    always_comb begin
        status         = '0;
        status[31]     = busy;
        status[32]     = done;
        status[33:35]  = pia;
`ifdef IOB_TIMED_DEVICE_OVERRUN_EN
        status[30]     = ovr;
`endif
    end

    assign iob_read = ({36{datai_act}} & db) | ({36{iob_fm_status && sel}} & status);

    always_comb begin
        pi_n = '0;
        for (int n = 1; n <= 7; n++) begin
            if (req_active && (pia == 3'(n)))
                pi_n[n] = 1'b1;
        end
    end

    // Later assignments win: the order below encodes the in-cycle priority,
    // with datao_set able to restart a timer that is expiring this clock.
    always_comb begin
        db_n   = db;
        pia_n  = pia;
        busy_n = busy;
        done_n = done;
        cnt_n  = cnt;

        if (sel && datao_clear)
            db_n = '0;
        if (sel && datao_set)
            db_n = db_n | iob_write;

        if (sel && cono_set) begin
            pia_n  = pia | iob_write[33:35];
            done_n = done | iob_write[32];
            if (iob_write[31] && !busy) begin
                busy_n = 1'b1;
                cnt_n  = RELOAD;
            end
        end

        if (datai_edge)
            done_n = 1'b0;

        if (busy) begin
            if (cnt <= CNT_W'(1)) begin
                cnt_n  = '0;
                busy_n = 1'b0;
                done_n = 1'b1;
            end else begin
                cnt_n = cnt - CNT_W'(1);
            end
        end

        if (sel && datao_set) begin
            busy_n = 1'b1;
            done_n = 1'b0;
            cnt_n  = RELOAD;
        end

        if (sel && cono_clear) begin
            pia_n  = '0;
            busy_n = 1'b0;
            done_n = 1'b0;
            cnt_n  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            db         <= '0;
            pia        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            cnt        <= '0;
            datai_prev <= 1'b0;
            pi_req     <= '0;
        end else begin
            db         <= db_n;
            pia        <= pia_n;
            busy       <= busy_n;
            done       <= done_n;
            cnt        <= cnt_n;
            datai_prev <= datai_act;
            pi_req     <= pi_n;
        end
    end

endmodule

// File: tb/tb_iob_timed_device.sv
// Bench for iob_timed_device: directed bus scenarios, then random traffic
// compared against a timestamp-based reference model.
module tb_iob_timed_device;

    localparam int XFER = 16;

    logic        clk = 1'b0;
    logic        reset, iob_poweron, iob_reset;
    logic        datao_clear, datao_set, cono_clear, cono_set;
    logic        iob_fm_datai, iob_fm_status;
    logic [3:9]  ios;
    logic [0:35] iob_write;
    logic [1:7]  pi_req;
    logic [0:35] iob_read;

    int checks = 0;
    int errors = 0;

    // reference model: flags plus the absolute edge number where DONE arrives
    logic [0:35] m_db;
    logic [2:0]  m_pia;
    logic        m_busy, m_done, m_ovr, m_prev;
    logic [1:7]  m_pi;
    int          m_cyc, m_done_at;

    iob_timed_device dut (
        .clk(clk), .reset(reset), .iob_poweron(iob_poweron), .iob_reset(iob_reset),
        .datao_clear(datao_clear), .datao_set(datao_set),
        .cono_clear(cono_clear), .cono_set(cono_set),
        .iob_fm_datai(iob_fm_datai), .iob_fm_status(iob_fm_status),
        .ios(ios), .iob_write(iob_write), .pi_req(pi_req), .iob_read(iob_read)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%o expected=%o", tag, obs, exp);
        end
    endtask

    function automatic logic [35:0] m_status();
        logic [35:0] s = '0;
        s[2:0] = m_pia;
        s[3]   = m_done;
        s[4]   = m_busy;
        s[5]   = m_ovr;
        return s;
    endfunction

    function automatic logic [35:0] m_read();
        logic        s = (ios == 7'o070);
        logic [35:0] r = '0;
        if (s && iob_fm_datai)  r = r | m_db;
        if (s && iob_fm_status) r = r | m_status();
        return r;
    endfunction

    task automatic model_update();
        logic        rst_m = !reset || !iob_poweron || iob_reset;
        logic        s = (ios == 7'o070);
        logic        expiry, first;
        logic [0:35] ndb;
        logic [2:0]  np;
        logic        nb, nd, nov;
        logic [1:7]  npi = '0;
        m_cyc++;
        if ((m_done || m_ovr) && m_pia != 0) npi[m_pia] = 1'b1;
        if (rst_m) begin
            m_db = '0; m_pia = '0; m_busy = 0; m_done = 0; m_ovr = 0;
            m_prev = 0; m_pi = '0;
            return;
        end
        expiry = m_busy && (m_cyc == m_done_at);
        first  = s && iob_fm_datai && !m_prev;
        ndb = m_db; np = m_pia; nb = m_busy; nd = m_done; nov = m_ovr;
        if (s && datao_clear) ndb = '0;
        if (s && datao_set)   ndb = ndb | iob_write;
        if (s && cono_set) begin
            np = np | iob_write[33:35];
            nd = nd | iob_write[32];
            if (iob_write[31] && !m_busy) begin
                nb = 1; m_done_at = m_cyc + XFER;
            end
        end
        if (first) nd = 0;
        if (expiry) begin nb = 0; nd = 1; end
        if (s && datao_set) begin
            nb = 1; nd = 0; m_done_at = m_cyc + XFER;
`ifdef IOB_TIMED_DEVICE_OVERRUN_EN
            if (m_busy) nov = 1;
`endif
        end
        if (s && cono_clear) begin np = 0; nb = 0; nd = 0; nov = 0; end
        m_db = ndb; m_pia = np; m_busy = nb; m_done = nd; m_ovr = nov;
        m_prev = s && iob_fm_datai;
        m_pi = npi;
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        datao_clear = 0; datao_set = 0; cono_clear = 0; cono_set = 0;
        iob_fm_datai = 0; iob_fm_status = 0; iob_write = '0; ios = 7'o070;
    endtask

    initial begin
        m_db = '0; m_pia = '0; m_busy = 0; m_done = 0; m_ovr = 0; m_prev = 0;
        m_pi = '0; m_cyc = 0; m_done_at = 0;
        reset = 0; iob_poweron = 1; iob_reset = 0;
        idle_bus();
        #2;
        step();
        chk("reset_pi", 36'(pi_req), 36'h0);
        iob_fm_status = 1; #1;
        chk("reset_status", 36'(iob_read), 36'o0);
        iob_fm_status = 0;

        // configure PIA=5
        reset = 1;
        cono_set = 1; iob_write = 36'o000000000005;
        step();
        cono_set = 0; iob_write = '0; iob_fm_status = 1; #1;
        chk("coni_pia5", 36'(iob_read), 36'o5);
        step();
        chk("pi_idle", 36'(pi_req), 36'h0);

        // transfer: DONE exactly XFER clocks after the datao_set edge
        iob_fm_status = 0;
        datao_clear = 1; step();
        datao_clear = 0; datao_set = 1; iob_write = 36'o123456701234; step();
        datao_set = 0; iob_write = '0;
        iob_fm_datai = 1; #1;
        chk("datai_db", 36'(iob_read), 36'o123456701234);
        iob_fm_datai = 0; iob_fm_status = 1; #1;
        for (int i = 1; i < XFER; i++) begin
            chk("busy_phase", 36'(iob_read), 36'o25);
            step();
        end
        chk("busy_last", 36'(iob_read), 36'o25);
        step();
        chk("done_set", 36'(iob_read), 36'o15);
        chk("pi_lag", 36'(pi_req), 36'h0);
        step();
        chk("pi_ch5", 36'(pi_req), 36'(7'b0000100));

        // held DATAI strobe clears DONE once
        iob_fm_status = 0; iob_fm_datai = 1;
        step();
        chk("pi_still", 36'(pi_req), 36'(7'b0000100));
        iob_fm_status = 1; #1;
        chk("datai_clr", 36'(iob_read), 36'o123456701234 | 36'o05);
        iob_fm_status = 0;
        step();
        chk("pi_cleared", 36'(pi_req), 36'h0);
        step();
        datao_set = 1; iob_write = 36'o1; step();
        datao_set = 0; iob_write = '0;
        for (int i = 0; i < XFER; i++) step();
        iob_fm_status = 1; #1;
        chk("held_no_clr", 36'(iob_read), 36'o123456701235 | 36'o15);
        chk("held_model", 36'(iob_read), m_read());
        iob_fm_datai = 0; iob_fm_status = 0;

        // wrong device code: no effect, no drive
        ios = 7'o071;
        datao_clear = 1; datao_set = 1; cono_clear = 1; cono_set = 1;
        iob_write = '1; iob_fm_datai = 1; iob_fm_status = 1; #1;
        chk("unsel_read", 36'(iob_read), 36'o0);
        step();
        idle_bus(); iob_fm_status = 1; #1;
        chk("unsel_state", 36'(iob_read), 36'o15);
        iob_fm_status = 0;

        // bus reset mid-transfer
        datao_set = 1; iob_write = 36'o777; step();
        datao_set = 0; iob_write = '0;
        for (int i = 0; i < 9; i++) step();
        iob_reset = 1; step();
        iob_reset = 0;
        for (int i = 0; i < XFER + 4; i++) step();
        iob_fm_status = 1; iob_fm_datai = 1; #1;
        chk("ioreset_abort", 36'(iob_read), 36'o0);
        chk("ioreset_pi", 36'(pi_req), 36'h0);
        iob_fm_status = 0; iob_fm_datai = 0;

        // second datao_set while busy
        cono_set = 1; iob_write = 36'o5; step();
        cono_set = 0; datao_set = 1; iob_write = 36'o1; step();
        datao_set = 0; step(); step();
        datao_set = 1; step();
        datao_set = 0; iob_write = '0; iob_fm_status = 1; #1;
`ifdef IOB_TIMED_DEVICE_OVERRUN_EN
        chk("overrun_flag", 36'(iob_read), 36'o65);
        step();
        chk("overrun_pi", 36'(pi_req), 36'(7'b0000100));
`else
        chk("no_overrun", 36'(iob_read), 36'o25);
        step();
        chk("no_overrun_pi", 36'(pi_req), 36'h0);
`endif
        cono_clear = 1; step();
        cono_clear = 0; #1;
        chk("cono_clear", 36'(iob_read), 36'o0);
        iob_fm_status = 0;

        // random traffic against the model
        for (int i = 0; i < 600; i++) begin
            reset        = ($urandom_range(0, 99) != 0);
            iob_poweron  = ($urandom_range(0, 149) != 0);
            iob_reset    = ($urandom_range(0, 149) == 0);
            ios          = ($urandom_range(0, 3) != 0) ? 7'o070 : 7'($urandom);
            datao_clear  = ($urandom_range(0, 24) == 0);
            datao_set    = ($urandom_range(0, 19) == 0);
            cono_clear   = ($urandom_range(0, 39) == 0);
            cono_set     = ($urandom_range(0, 14) == 0);
            iob_fm_datai = ($urandom_range(0, 5) == 0);
            iob_fm_status = ($urandom_range(0, 2) == 0);
            iob_write    = {4'($urandom), 32'($urandom)};
            #1;
            chk("rnd_read", 36'(iob_read), m_read());
            step();
            chk("rnd_pi", 36'(pi_req), 36'(m_pi));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/iob_timed_device.md
Name: iob_timed_device

Overview:
- Generic PDP-6 I/O-bus slave device that connects to one slave port of the IOB fan-out/OR-combine stage.
- Decodes its device code from the bus, holds a 36-bit data buffer (DB) and a CONO/CONI status register, and runs a programmable busy timer after each DATAO.
- Raises a priority-interrupt request on its assigned channel when the timer completes.
- Serves as the reference peripheral and test target for bus-level simulation.

Parameters:
- DEVICE_CODE, 7'o070: device number matched against ios[3:9].
- XFER_CYCLES, 16: busy duration in clk cycles after a transfer starts (≥1).
- CNT_W, 8: timer counter width; XFER_CYCLES < 2**CNT_W.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous reset, active-low
- iob_poweron  in  1  bus power-on; low is treated as reset
- iob_reset  in  1  bus I/O reset pulse
- datao_clear  in  1  DATAO clear pulse (1 clk)
- datao_set  in  1  DATAO set pulse (1 clk)
- cono_clear  in  1  CONO clear pulse (1 clk)
- cono_set  in  1  CONO set pulse (1 clk)
- iob_fm_datai  in  1  DATAI read strobe (level)
- iob_fm_status  in  1  CONI read strobe (level)
- ios  in  7 [3:9]  device select code
- iob_write  in  36 [0:35]  bus data from the processor; bit 0 is MSB
- pi_req  out  7 [1:7]  PI request, one-hot by channel
- iob_read  out  36 [0:35]  data to the processor; zero when not driving

Behaviour:
- sel = (ios == DEVICE_CODE). All bus actions are qualified by sel.
- Reset (reset==0 or iob_poweron==0 or iob_reset==1, sampled at posedge):
  - DB, PIA, BUSY, DONE and counter are all 0.
  - pi_req = 0. iob_read follows its combinational rule.
  - An in-progress transfer is aborted and DONE is not set.
- Status word:
  - PIA = bits 33..35.
  - DONE = bit 32.
  - BUSY = bit 31.
  - All other bits read 0.
- datao_clear & sel: DB <= 0.
- datao_set & sel:
  - DB <= DB | iob_write.
  - BUSY <= 1, DONE <= 0, counter <= XFER_CYCLES.
- cono_clear & sel: PIA, BUSY and DONE <= 0; counter stopped.
- cono_set & sel: PIA |= iob_write[33:35], DONE |= iob_write[32], BUSY |= iob_write[31].
  - If BUSY goes 0→1 through this path, counter <= XFER_CYCLES.
- Timer while BUSY:
  - Counter decrements by 1 each clk.
  - On the clk where the counter reads 1: counter <= 0, BUSY <= 0, DONE <= 1.
  - DONE is therefore set exactly XFER_CYCLES clks after the datao_set edge.
- DATAI (iob_fm_datai & sel):
  - iob_read = DB, combinational.
  - DONE is cleared on the first clk edge where the strobe is seen high; a held strobe clears it only once.
- CONI (iob_fm_status & sel): iob_read = status word, combinational. No side effects.
- Both strobes high: iob_read = DB | status.
- No strobe, or sel low: iob_read = 0.
- pi_req[n] = DONE & (PIA == n) for n = 1..7. PIA==0 requests nothing. pi_req is registered, one clk after DONE/PIA change.
- Priority within one clk: reset > cono_clear > timer expiry > DATAI clear of DONE > cono_set.
  - Expiry in the same clk as a DATAI read leaves DONE=1.
- datao_clear and datao_set in the same clk: the result is iob_write (clear then set).
- datao_set while BUSY: DB is ORed and the counter restarts.

Optional Feature:
- Macro IOB_TIMED_DEVICE_OVERRUN_EN.
- Defined:
  - Adds an OVERRUN flag at status bit 30.
  - OVERRUN is set when datao_set & sel arrives while BUSY.
  - Cleared by reset or cono_clear.
  - While set it forces pi_req[PIA] regardless of DONE.
- Undefined: no flag, bit 30 reads 0, and datao_set while BUSY behaves as specified above.

Test Plan:
- Reset low 1 clk, then cono_set with ios=070, iob_write=36'o000000000005 → CONI reads 36'o5; pi_req=0; DONE=0.
- With PIA=5: datao_clear then datao_set, iob_write=36'o123456701234 → DATAI reads 36'o123456701234; CONI shows BUSY until 16 clks later, then DONE=1; pi_req=7'b0000100 one clk after DONE.
- DATAI strobe held 3 clks after DONE → DONE clears after the first clk; pi_req returns to 0 one clk later; the held strobe does not affect later transfers.
- ios=071 with all pulses asserted → no state change; iob_read=0.
- iob_reset pulsed mid-transfer (counter=7) → BUSY=0, DONE never sets; DB=0.
- With the macro defined: second datao_set while BUSY → CONI bit 30=1 and pi_req[PIA] asserted; cono_clear clears bit 30. With the macro undefined: bit 30 reads 0.
